// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ byte producers with round-robin
// arbitration. A grant acks the winner and latches its byte. The transmitter is
// then strobed, and the arbiter waits for its completion interrupt. A watchdog
// bounds that wait. A fixed inter-frame gap follows each frame so that the
// transmitter is idle again before the next launch.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_enable     1 = new grants allowed; an in-flight frame always completes
//   i_req        per-requester level request, held with data until ack
//   i_data       flattened bytes, requester k at [k*DATA_W +: DATA_W]
//   o_ack        one-cycle pulse to the granted requester (byte captured)
//   o_tx_start   one-cycle data-valid strobe to the transmitter
//   o_tx_data    byte to the transmitter, stable from grant to next grant
//   i_tx_done    transmitter completion interrupt (single-cycle pulse)
//   o_busy       1 whenever the arbiter is not idle
//   o_grant_id   index of the current/last granted requester
//   o_timeout    one-cycle pulse when the watchdog expires
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 60000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         o_tx_data,
  input  logic                      i_tx_done,
  output logic                      o_busy,
  output logic [2:0]                o_grant_id,
  output logic                      o_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_t              state;
  logic [2:0]          rr_ptr;
  logic [15:0]         timer;
  logic [15:0]         gap_cnt;

  logic [7:0]          req_ext;
  logic                win_found;
  logic [2:0]          win_id;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [DATA_W-1:0]   win_data;
  int                  slot;

  // Round-robin search starting just after the last winner. The request vector
  // is widened to 8 bits so that a 3-bit slot index always selects in range.
  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = i_req;
    win_found = 1'b0;
    win_id    = 3'd0;
    slot      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      slot = int'(rr_ptr) + i;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!win_found && req_ext[3'(slot)]) begin
        win_found = 1'b1;
        win_id    = 3'(slot);
      end
    end
    win_onehot = '0;
    win_data   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_id == 3'(k)) begin
        win_onehot[k] = 1'b1;
        win_data      = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // o_busy is updated together with every state change so that it always
  // reflects the registered state without a combinational decode.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      rr_ptr     <= 3'(NUM_REQ - 1);
      timer      <= '0;
      gap_cnt    <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_grant_id <= 3'd0;
      o_timeout  <= 1'b0;
    end else begin
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_enable && win_found) begin
            o_tx_data  <= win_data;
            o_ack      <= win_onehot;
            o_grant_id <= win_id;
            rr_ptr     <= win_id;
            o_busy     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          o_tx_start <= 1'b1;
          timer      <= '0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          timer <= timer + 16'd1;
          // Completion takes priority over a watchdog expiry on the same cycle.
          if (i_tx_done) begin
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timer == TIMER_LAST) begin
            o_timeout <= 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk;
  logic                      rst_n;
  logic                      enable;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        o_ack;
  logic                      o_tx_start;
  logic [DATA_W-1:0]         o_tx_data;
  logic                      tx_done;
  logic                      o_busy;
  logic [2:0]                o_grant_id;
  logic                      o_timeout;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(100), .GAP_CYCLES(2)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(enable), .i_req(req),
    .i_data(data), .o_ack(o_ack), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .i_tx_done(tx_done), .o_busy(o_busy),
    .o_grant_id(o_grant_id), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    enable  = 1'b1;
    req     = '0;
    data    = '0;
    tx_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_ack(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      n++;
      if (o_ack != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b start=%b data=%h busy=%b gid=%0d to=%b, want all 0",
               o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout);
    end
  endtask

  task automatic test_single();
    int n; bit ok;
    do_reset();
    data = 32'h0000_00A5;
    req  = 4'b0001;
    wait_ack(10, n, ok);
    checks++;
    if (!ok || n != 1 || o_ack !== 4'b0001) begin
      failures++;
      $display("FAIL single_ack: got ack=%b after %0d cycles, want 0001 after 1", o_ack, n);
    end
    req = '0;
    step();
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA5 || o_ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_launch: got start=%b data=%h ack=%b, want 1 a5 0000",
               o_tx_start, o_tx_data, o_ack);
    end
    repeat (20) step();
    checks++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_wait: got start=%b busy=%b, want 0 1", o_tx_start, o_busy);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gap: got busy=%b, want 1", o_busy);
    end
    step();
    checks++;
    if (o_busy !== 1'b0 || o_tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_idle: got busy=%b data=%h, want 0 a5", o_busy, o_tx_data);
    end
  endtask

  task automatic test_round_robin();
    int n; bit ok; int exp_id;
    logic [7:0] exp_byte;
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req  = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id   = g % 4;
      exp_byte = data[exp_id*8 +: 8];
      wait_ack(20, n, ok);
      checks++;
      if (!ok || o_ack !== 4'(1 << exp_id) || o_grant_id !== 3'(exp_id)
          || n != ((g == 0) ? 1 : 3)) begin
        failures++;
        $display("FAIL rr_grant%0d: got ack=%b gid=%0d after %0d cycles, want id %0d after %0d",
                 g, o_ack, o_grant_id, n, exp_id, (g == 0) ? 1 : 3);
      end
      step();
      checks++;
      if (o_tx_start !== 1'b1 || o_tx_data !== exp_byte || o_ack !== 4'b0000) begin
        failures++;
        $display("FAIL rr_launch%0d: got start=%b data=%h ack=%b, want 1 %h 0000",
                 g, o_tx_start, o_tx_data, o_ack, exp_byte);
      end
      repeat (3) step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
    end
    req = '0;
    repeat (4) step();
  endtask

  task automatic test_timeout();
    int n; bit ok; bit seen;
    do_reset();
    data = 32'h00C3_0077;
    req  = 4'b0100;
    wait_ack(10, n, ok);
    checks++;
    if (!ok || o_ack !== 4'b0100 || o_grant_id !== 3'd2) begin
      failures++;
      $display("FAIL to_grant: got ack=%b gid=%0d, want 0100 2", o_ack, o_grant_id);
    end
    req = 4'b0001;
    step();
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      n++;
      if (o_timeout) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 100) begin
      failures++;
      $display("FAIL to_pulse: got seen=%b at %0d cycles after start, want 1 at 100", seen, n);
    end
    step();
    checks++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL to_width: got timeout=%b busy=%b, want 0 1", o_timeout, o_busy);
    end
    wait_ack(10, n, ok);
    checks++;
    if (!ok || n != 2 || o_ack !== 4'b0001 || o_tx_data !== 8'h77) begin
      failures++;
      $display("FAIL to_next: got ack=%b data=%h after %0d cycles, want 0001 77 after 2",
               o_ack, o_tx_data, n);
    end
    req = '0;
    step();
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_coincidence();
    int n; bit ok; bit seen;
    do_reset();
    data = 32'h0000_005A;
    req  = 4'b0001;
    wait_ack(10, n, ok);
    req = '0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (o_timeout) seen = 1'b1;
    end
    checks++;
    if (seen || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL co_early: got early timeout=%b busy=%b, want 0 1", seen, o_busy);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    seen = o_timeout;
    step();
    if (o_timeout) seen = 1'b1;
    step();
    checks++;
    if (seen || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL co_done_wins: got timeout=%b busy=%b, want 0 0", seen, o_busy);
    end
  endtask

  task automatic test_stray_withdraw();
    int n; bit ok;
    logic [NUM_REQ-1:0] ack_seen;
    logic start_seen;
    do_reset();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    checks++;
    if (o_busy !== 1'b0 || o_ack !== 4'b0000 || o_tx_start !== 1'b0) begin
      failures++;
      $display("FAIL stray_done: got busy=%b ack=%b start=%b, want 0 0000 0",
               o_busy, o_ack, o_tx_start);
    end
    data = 32'h0000_2200 | 32'h0000_0033;
    req  = 4'b0001;
    wait_ack(10, n, ok);
    req = '0;
    step();
    step();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    ack_seen   = '0;
    start_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      ack_seen   = ack_seen | o_ack;
      start_seen = start_seen | o_tx_start;
    end
    checks++;
    if (ack_seen !== 4'b0000 || start_seen !== 1'b0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL withdraw: got ack_seen=%b start_seen=%b busy=%b, want 0000 0 0",
               ack_seen, start_seen, o_busy);
    end
  endtask

  task automatic test_enable();
    int n; bit ok;
    logic [NUM_REQ-1:0] ack_seen;
    do_reset();
    enable = 1'b0;
    data   = 32'h0000_6600;
    req    = 4'b0010;
    ack_seen = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      ack_seen = ack_seen | o_ack;
    end
    checks++;
    if (ack_seen !== 4'b0000 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL en_blocked: got ack_seen=%b busy=%b, want 0000 0", ack_seen, o_busy);
    end
    enable = 1'b1;
    wait_ack(10, n, ok);
    checks++;
    if (!ok || n != 1 || o_ack !== 4'b0010 || o_grant_id !== 3'd1) begin
      failures++;
      $display("FAIL en_grant: got ack=%b gid=%0d after %0d, want 0010 1 after 1",
               o_ack, o_grant_id, n);
    end
    enable = 1'b0;
    step();
    checks++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h66) begin
      failures++;
      $display("FAIL en_inflight: got start=%b data=%h, want 1 66", o_tx_start, o_tx_data);
    end
    repeat (2) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    ack_seen = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      ack_seen = ack_seen | o_ack;
    end
    checks++;
    if (ack_seen !== 4'b0000 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL en_hold: got ack_seen=%b busy=%b, want 0000 0", ack_seen, o_busy);
    end
    enable = 1'b1;
    wait_ack(10, n, ok);
    checks++;
    if (!ok || n != 1 || o_ack !== 4'b0010) begin
      failures++;
      $display("FAIL en_rewin: got ack=%b after %0d, want 0010 after 1", o_ack, n);
    end
    req = '0;
  endtask

  task automatic test_reset_midframe();
    int n; bit ok;
    do_reset();
    data = 32'h00E7_0000;
    req  = 4'b0100;
    wait_ack(10, n, ok);
    req = '0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout} !== '0) begin
      failures++;
      $display("FAIL rst_mid: got ack=%b start=%b data=%h busy=%b gid=%0d to=%b, want all 0",
               o_ack, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout);
    end
    step();
    rst_n = 1'b1;
    data  = 32'h9900_0011;
    req   = 4'b1001;
    wait_ack(10, n, ok);
    checks++;
    if (!ok || o_ack !== 4'b0001 || o_grant_id !== 3'd0) begin
      failures++;
      $display("FAIL rst_ptr: got ack=%b gid=%0d, want 0001 0", o_ack, o_grant_id);
    end
    req = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b1;
    req     = '0;
    data    = '0;
    tx_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincidence();
    test_stray_withdraw();
    test_enable();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
